// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the latency-modelled bench memory.
package mem_model_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Value returned by a read that falls outside the storage array.
  localparam int unsigned OOR_RDATA = 0;

  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter; saturates at zero and flags it.
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_model_lat.sv
// Word-addressed memory with independent read/write latency and a
// memory_ready handshake, for driving a core's memory interface in benches.
module mem_model_lat
  import mem_model_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 3,
  parameter int CHANGE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              memory_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              memory_ready,
  output logic              busy,
  output logic              error
);

  localparam int CNT_W = cnt_width(RD_LAT, WR_LAT);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  generate
    if (RD_LAT < 1 || WR_LAT < 1 || (ADDR_W < 31 && DEPTH > (1 << ADDR_W))) begin : g_bad_params
      $error("mem_model_lat: latencies must be >= 1 and DEPTH must fit in ADDR_W");
    end
  endgenerate

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic              r_error;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_start;
  logic              w_accept;
  logic              w_cnt_zero;
  logic              w_complete;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_load_val;

  // Legacy mode starts on any address change; req is then ignored.
  assign w_start    = (CHANGE_MODE != 0) ? (addr != r_last_addr) : req;
  assign w_accept   = (r_state == ST_IDLE) && w_start;
  assign w_complete = (r_state == ST_WAIT) && w_cnt_zero;
  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];
  assign w_load_val = memory_w ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);

  mem_lat_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_cnt_zero)
  );

  // Storage is not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_complete && r_we && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_last_addr <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_addr      <= addr;
            r_last_addr <= addr;
            r_we        <= memory_w;
            r_wdata     <= wdata;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_cnt_zero) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_error <= !w_in_range;
            r_state <= ST_IDLE;
            if (!r_we) begin
              r_rdata <= w_in_range ? r_mem[w_idx] : DATA_W'(OOR_RDATA);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdata        = r_rdata;
  assign memory_ready = r_ready;
  assign busy         = r_busy;
  assign error        = r_error;

endmodule

// File: tb/tb_mem_model_lat.sv
// Directed bench: default-config instance plus a CHANGE_MODE=1, RD_LAT=4 instance.
module tb_mem_model_lat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        memory_w;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        memory_ready;
  logic        busy;
  logic        error;

  logic        req1;
  logic        memory_w1;
  logic [15:0] addr1;
  logic [15:0] wdata1;
  logic [15:0] rdata1;
  logic        memory_ready1;
  logic        busy1;
  logic        error1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_model_lat u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .memory_w     (memory_w),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .memory_ready (memory_ready),
    .busy         (busy),
    .error        (error)
  );

  mem_model_lat #(
    .RD_LAT      (4),
    .CHANGE_MODE (1)
  ) u_dut_chg (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req1),
    .memory_w     (memory_w1),
    .addr         (addr1),
    .wdata        (wdata1),
    .rdata        (rdata1),
    .memory_ready (memory_ready1),
    .busy         (busy1),
    .error        (error1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let it be accepted on the next edge, then drop req.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
    req = 1'b1; memory_w = we; addr = a; wdata = d;
    step();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({memory_ready, busy, error, rdata} !== 19'h0)
      $display("FAIL reset_hold: ready=%b busy=%b err=%b rdata=%h expected 0/0/0/0000", memory_ready, busy, error, rdata);
    else passes++;
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({memory_ready, busy, error, rdata} !== 19'h0)
      $display("FAIL reset_idle: ready=%b busy=%b err=%b rdata=%h expected 0/0/0/0000", memory_ready, busy, error, rdata);
    else passes++;
    $display("reset: ready=%b busy=%b err=%b rdata=%h", memory_ready, busy, error, rdata);
  endtask

  task automatic test_write_read();
    logic [2:0] rdy_seq;
    issue(1'b1, 16'h0005, 16'hBEEF);
    checks++;
    if (busy !== 1'b1 || memory_ready !== 1'b0)
      $display("FAIL wr_accept: busy=%b ready=%b expected 1/0", busy, memory_ready);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      rdy_seq[i] = memory_ready;
    end
    checks++;
    if (rdy_seq !== 3'b100)
      $display("FAIL wr_latency: ready per edge=%b expected 100", rdy_seq);
    else passes++;
    checks++;
    if (busy !== 1'b0 || error !== 1'b0 || rdata !== 16'h0000)
      $display("FAIL wr_done: busy=%b err=%b rdata=%h expected 0/0/0000", busy, error, rdata);
    else passes++;
    $display("write 0005<=BEEF: ready edges=%b", rdy_seq);

    issue(1'b0, 16'h0005, 16'h0000);
    step();
    checks++;
    if (memory_ready !== 1'b0)
      $display("FAIL rd_early: ready=%b expected 0 one edge after accept", memory_ready);
    else passes++;
    step();
    checks++;
    if (memory_ready !== 1'b1 || rdata !== 16'hBEEF || error !== 1'b0)
      $display("FAIL rd_data: ready=%b rdata=%h err=%b expected 1/BEEF/0", memory_ready, rdata, error);
    else passes++;
    $display("read 0005: rdata=%h ready=%b", rdata, memory_ready);
  endtask

  task automatic test_busy_drop();
    int busy_cycles = 0;
    int rises = 0;
    logic prev_rdy;
    issue(1'b0, 16'h0005, 16'h0000);
    prev_rdy = memory_ready;
    if (busy) busy_cycles++;
    req = 1'b1; addr = 16'h0009;
    step();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cycles++;
      if (memory_ready && !prev_rdy) rises++;
      prev_rdy = memory_ready;
      step();
    end
    checks++;
    if (busy_cycles != 2)
      $display("FAIL busy_len: busy cycles=%0d expected 2", busy_cycles);
    else passes++;
    checks++;
    if (rises != 1)
      $display("FAIL busy_single: completions=%0d expected 1", rises);
    else passes++;
    checks++;
    if (rdata !== 16'hBEEF)
      $display("FAIL busy_ignored: rdata=%h expected BEEF", rdata);
    else passes++;
    $display("busy drop: busy=%0d completions=%0d rdata=%h", busy_cycles, rises, rdata);
  endtask

  task automatic test_out_of_range();
    logic [3:0] err_seq;
    issue(1'b1, 16'h0000, 16'h5A5A);
    repeat (3) step();
    issue(1'b1, 16'h0400, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      step();
      err_seq[i] = error;
    end
    checks++;
    if (err_seq !== 4'b0100)
      $display("FAIL oor_wr_err: error per edge=%b expected 0100", err_seq);
    else passes++;
    issue(1'b0, 16'h0400, 16'h0000);
    step();
    step();
    checks++;
    if (rdata !== 16'h0000 || error !== 1'b1 || memory_ready !== 1'b1)
      $display("FAIL oor_rd: rdata=%h err=%b ready=%b expected 0000/1/1", rdata, error, memory_ready);
    else passes++;
    issue(1'b0, 16'h0000, 16'h0000);
    step();
    step();
    checks++;
    if (rdata !== 16'h5A5A || error !== 1'b0)
      $display("FAIL oor_no_alias: rdata=%h err=%b expected 5A5A/0", rdata, error);
    else passes++;
    $display("out of range: err edges=%b read 0000=%h", err_seq, rdata);
  endtask

  task automatic test_change_mode();
    logic [3:0] rdy_seq;
    checks++;
    if (memory_ready1 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL chg_idle: ready=%b busy=%b expected 0/0", memory_ready1, busy1);
    else passes++;
    addr1 = 16'h0010;
    step();
    checks++;
    if (busy1 !== 1'b1 || memory_ready1 !== 1'b0)
      $display("FAIL chg_accept: busy=%b ready=%b expected 1/0", busy1, memory_ready1);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      rdy_seq[i] = memory_ready1;
    end
    checks++;
    if (rdy_seq !== 4'b1000)
      $display("FAIL chg_latency: ready per edge=%b expected 1000", rdy_seq);
    else passes++;
    repeat (4) step();
    checks++;
    if (memory_ready1 !== 1'b1 || busy1 !== 1'b0)
      $display("FAIL chg_same_addr: ready=%b busy=%b expected 1/0", memory_ready1, busy1);
    else passes++;
    $display("change mode: ready edges=%b held ready=%b", rdy_seq, memory_ready1);
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 16'h0007, 16'h1111);
    repeat (3) step();
    issue(1'b1, 16'h0007, 16'hAAAA);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (memory_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || rdata !== 16'h0000)
      $display("FAIL midrst_out: ready=%b busy=%b err=%b rdata=%h expected 0/0/0/0000", memory_ready, busy, error, rdata);
    else passes++;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    issue(1'b0, 16'h0007, 16'h0000);
    step();
    step();
    checks++;
    if (memory_ready !== 1'b1 || rdata !== 16'h1111)
      $display("FAIL midrst_discard: ready=%b rdata=%h expected 1/1111", memory_ready, rdata);
    else passes++;
    $display("reset mid-write: read 0007=%h", rdata);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; memory_w = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; memory_w1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_read();
    test_busy_drop();
    test_out_of_range();
    test_change_mode();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_model_lat.md
Name: mem_model_lat

Overview:
- Parametrised successor of the bench memory-latency model used against ControlUnit.
- Real storage array with configurable data/address width and depth.
- Independent read and write latencies; explicit request strobe, or legacy address-change start mode.
- Sits between the core's memory interface (addr, memory_w, data) and the unit under test in benches. Synthesisable for FPGA bring-up.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 16, data width in bits
DEPTH, 1024, number of words; addresses >= DEPTH are out of range
RD_LAT, 2, cycles from accepted read to memory_ready (must be >= 1)
WR_LAT, 3, cycles from accepted write to memory_ready (must be >= 1)
CHANGE_MODE, 0, 0 = start on req; 1 = start when addr differs from last accepted addr (req ignored)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  1  request strobe (CHANGE_MODE=0), sampled only in IDLE
memory_w  in  1  1 = write, 0 = read; captured at accept
addr  in  ADDR_W  word address; captured at accept
wdata  in  DATA_W  write data; captured at accept
rdata  out  DATA_W  read data; valid while memory_ready=1 after a read
memory_ready  out  1  level: last accepted op complete, block idle
busy  out  1  operation in flight
error  out  1  one-cycle pulse coinciding with memory_ready rise on an out-of-range access

Behaviour:
- Reset (asserted anywhere, including mid-operation): state IDLE, memory_ready=0, busy=0, error=0, rdata=0, last_addr=0, counter=0. Any in-flight write is discarded. Array contents are not reset.
- States: IDLE, WAIT.
- IDLE:
  - Start condition: req=1 (CHANGE_MODE=0), or addr!=last_addr (CHANGE_MODE=1).
  - On a start edge: capture addr, memory_w, wdata; last_addr<=addr; memory_ready<=0; busy<=1; counter<=LAT-1, where LAT=WR_LAT if write else RD_LAT; go to WAIT.
- WAIT:
  - While counter!=0: decrement counter.
  - When counter==0: complete the op on that edge and return to IDLE.
  - Completion edge: memory_ready<=1; busy<=0.
    - Write: array[addr]<=wdata.
    - Read: rdata<=array[addr].
- memory_ready timing: rises exactly LAT edges after the accept edge. It stays 1 until the next accept edge clears it.
- Inputs during WAIT are ignored: no queuing. The master must hold req until it sees memory_ready rise. The earliest next accept is the edge after completion, so back-to-back throughput is one op per LAT+1 cycles.
- Out of range (captured addr >= DEPTH):
  - Full latency is still applied.
  - On completion, error=1 for one cycle.
  - A write is discarded; a read returns rdata=0.
- In-range completion: error=0.
- rdata holds its value through writes and idle periods. It changes only on a read completion or reset.
- Read after write to the same address returns the new data.
- CHANGE_MODE=1, same address re-issued: no start, memory_ready stays 1. This is the legacy behaviour.
- RD_LAT or WR_LAT < 1, or DEPTH > 2**ADDR_W: elaboration-time error.
- Counter width: clog2(max(RD_LAT,WR_LAT)+1).

Decomposition:
- Package mem_model_pkg:
  - state encoding (IDLE, WAIT);
  - function computing counter width from the latencies;
  - constant for the out-of-range read value (0).
- One sub-module, mem_lat_counter: loadable down-counter with load value, load strobe and zero flag.
- Array and FSM stay in mem_model_lat.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> memory_ready=0, busy=0, error=0, rdata=0 until the first request.
- Write then read, defaults: write addr 0x0005, wdata 0xBEEF, req 1 cycle -> memory_ready rises 3 edges later. Then read 0x0005 -> memory_ready rises 2 edges after accept, rdata=0xBEEF.
- Busy drop: read accepted, req pulsed again with a different addr during WAIT -> ignored; only one completion; busy high exactly RD_LAT cycles.
- Out of range, DEPTH=1024: write 0x0400 with 0x1234 -> error pulse 1 cycle at completion. Read 0x0400 -> rdata=0. Read 0x0000 -> unchanged prior value.
- CHANGE_MODE=1, RD_LAT=4: addr 0x0000->0x0010, memory_w=0 -> memory_ready low, rises after 4 edges. Addr held at 0x0010 -> no new op, memory_ready stays 1.
- Reset mid-write: write 0x0007 with 0xAAAA, rst_n low at the second WAIT cycle -> memory_ready=0, busy=0. A later read of 0x0007 returns the old value, not 0xAAAA.
